// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - instruction fetch stage with program-load port and valid/ready output
// Optional halt-on-opcode-111 behaviour is enabled by defining FETCH_HALT_EN.
module inst_fetch #(
  parameter int              PC_W     = 4,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load_we,
  input  logic [PC_W-1:0] load_addr,
  input  logic [7:0]      load_data,
  input  logic            run,
  output logic [7:0]      inst,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [PC_W-1:0] pc,
  output logic            halted
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_VALID
`ifdef FETCH_HALT_EN
    , S_HALT
`endif
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [7:0]      mem [2**PC_W];
  logic [PC_W-1:0] fpc;
  logic            fetch_ok;
  logic            do_fetch;

  // Load wins over fetch, so the read below never collides with a write.
  assign fetch_ok   = run & ~load_we;
  assign inst_valid = (state == S_VALID);

`ifdef FETCH_HALT_EN
  assign halted = (state == S_HALT);
`else
  assign halted = 1'b0;
`endif

  always_comb begin
    state_next = state;
    do_fetch   = 1'b0;
    case (state)
      S_IDLE: begin
        if (fetch_ok) begin
          do_fetch   = 1'b1;
          state_next = S_VALID;
        end
      end
      S_VALID: begin
        // Without inst_ready everything holds; run and load_we cannot disturb inst.
        if (inst_ready) begin
`ifdef FETCH_HALT_EN
          if (inst[7:5] == 3'b111) begin
            state_next = S_HALT;
          end else
`endif
          if (fetch_ok) begin
            do_fetch = 1'b1;
          end else begin
            state_next = S_IDLE;
          end
        end
      end
`ifdef FETCH_HALT_EN
      S_HALT: state_next = S_HALT;
`endif
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      fpc   <= RESET_PC;
      pc    <= RESET_PC;
      inst  <= 8'h00;
    end else begin
      state <= state_next;
      if (do_fetch) begin
        inst <= mem[fpc];
        pc   <= fpc;
        fpc  <= fpc + 1'b1;
      end
    end
  end

  // Program memory is deliberately left out of reset so a loaded program survives rst.
  always_ff @(posedge clk) begin
    if (load_we) begin
      mem[load_addr] <= load_data;
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// tb/tb_inst_fetch.sv - directed self-checking bench for inst_fetch
module tb_inst_fetch;

  logic       clk = 1'b0;
  logic       rst;
  logic       load_we;
  logic [3:0] load_addr;
  logic [7:0] load_data;
  logic       run;
  logic [7:0] inst;
  logic       inst_valid;
  logic       inst_ready;
  logic [3:0] pc;
  logic       halted;

  int checks = 0;
  int errors = 0;

  inst_fetch #(.PC_W(4), .RESET_PC(4'd0)) dut (
    .clk(clk), .rst(rst), .load_we(load_we), .load_addr(load_addr),
    .load_data(load_data), .run(run), .inst(inst), .inst_valid(inst_valid),
    .inst_ready(inst_ready), .pc(pc), .halted(halted)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_inst(input string tag, input logic [7:0] e_inst, input logic [3:0] e_pc);
    chk({tag, ".valid"}, {7'd0, inst_valid}, 8'd1);
    chk({tag, ".inst"}, inst, e_inst);
    chk({tag, ".pc"}, {4'd0, pc}, {4'd0, e_pc});
  endtask

  task automatic load(input logic [3:0] a, input logic [7:0] d);
    load_we = 1'b1; load_addr = a; load_data = d;
    @(negedge clk);
    load_we = 1'b0;
  endtask

  initial begin
    rst = 1'b1; load_we = 1'b0; load_addr = '0; load_data = '0; run = 1'b0; inst_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst.valid", {7'd0, inst_valid}, 8'd0);
    chk("rst.inst", inst, 8'h00);
    chk("rst.pc", {4'd0, pc}, 8'd0);
    chk("rst.halted", {7'd0, halted}, 8'd0);
    rst = 1'b0;

    load(4'd0, 8'h0B); load(4'd1, 8'h2A); load(4'd2, 8'h53); load(4'd3, 8'hA1);
    load(4'd4, 8'h11); load(4'd5, 8'h22);
    for (int i = 6; i < 15; i++) load(4'(i), 8'h30 + 8'(i));
    load(4'd15, 8'h44);
    chk("load.no_fetch", {7'd0, inst_valid}, 8'd0);

    // Streaming, then a 3-cycle stall with run dropped
    run = 1'b1; inst_ready = 1'b1;
    @(negedge clk); chk_inst("s0", 8'h0B, 4'd0);
    @(negedge clk); chk_inst("s1", 8'h2A, 4'd1);
    inst_ready = 1'b0; run = 1'b0;
    repeat (3) begin
      @(negedge clk); chk_inst("stall", 8'h2A, 4'd1);
    end
    inst_ready = 1'b1; run = 1'b1;
    @(negedge clk); chk_inst("s2", 8'h53, 4'd2);
    @(negedge clk); chk_inst("s3", 8'hA1, 4'd3);
    run = 1'b0;
    @(negedge clk); chk("stop.valid", {7'd0, inst_valid}, 8'd0);

    // Load pulse while streaming suppresses the fetch of that cycle
    run = 1'b1;
    @(negedge clk); chk_inst("b4", 8'h11, 4'd4);
    load_we = 1'b1; load_addr = 4'd5; load_data = 8'hC0;
    @(negedge clk); chk("ldpulse.valid", {7'd0, inst_valid}, 8'd0);
    load_we = 1'b0;
    @(negedge clk); chk_inst("b5", 8'hC0, 4'd5);
    run = 1'b0;
    @(negedge clk); chk("b.idle", {7'd0, inst_valid}, 8'd0);

    // Stream up to the top of memory and wrap
    load(4'd0, 8'h08);
    chk("c.idle", {7'd0, inst_valid}, 8'd0);
    run = 1'b1;
    for (int i = 6; i < 16; i++) begin
      @(negedge clk);
      chk_inst("wrapseq", (i == 15) ? 8'h44 : 8'h30 + 8'(i), 4'(i));
    end
    @(negedge clk); chk_inst("wrap0", 8'h08, 4'd0);
    run = 1'b0;
    @(negedge clk); chk("c.stop", {7'd0, inst_valid}, 8'd0);

    // Reserved opcode 111
    load(4'd1, 8'hE0); load(4'd2, 8'h5A);
    run = 1'b1;
    @(negedge clk); chk_inst("op7", 8'hE0, 4'd1);
    @(negedge clk);
`ifdef FETCH_HALT_EN
    chk("halt.halted", {7'd0, halted}, 8'd1);
    chk("halt.valid", {7'd0, inst_valid}, 8'd0);
    @(negedge clk);
    chk("halt.hold", {7'd0, halted}, 8'd1);
    chk("halt.valid2", {7'd0, inst_valid}, 8'd0);
`else
    chk("nohalt.halted", {7'd0, halted}, 8'd0);
    chk_inst("nohalt2", 8'h5A, 4'd2);
    @(negedge clk); chk_inst("nohalt3", 8'hA1, 4'd3);
`endif
    rst = 1'b1; run = 1'b0;
    @(negedge clk);
    chk("rst2.halted", {7'd0, halted}, 8'd0);
    chk("rst2.valid", {7'd0, inst_valid}, 8'd0);
    chk("rst2.inst", inst, 8'h00);
    chk("rst2.pc", {4'd0, pc}, 8'd0);
    rst = 1'b0;

    // Memory survives reset
    run = 1'b1;
    @(negedge clk); chk_inst("postrst", 8'h08, 4'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
